// File: rtl/sram_arbiter.sv
// Purpose : shares one single-port SRAM between the Ibex instruction and data ports.
// Latency : grant is combinational in the request cycle; response follows 1 cycle later.
// Backpressure: the losing port simply sees gnt=0 and must hold its request; nothing is queued.
//
// Ports:
//   clk_sys, rst_sys_n            clock, asynchronous active-low reset
//   instr_* (req/addr -> gnt/rvalid/rdata/err)            instruction fetch port
//   data_*  (req/we/be/addr/wdata -> gnt/rvalid/rdata/err) load/store port
//   mem_*   (req/we/be/addr/wdata -> rvalid/rdata)        SRAM side, 1-cycle read latency
module sram_arbiter #(
  parameter logic [31:0] MemStart    = 32'h0000_0000,
  parameter logic [31:0] MemMask     = 32'h0000_FFFF,
  parameter int unsigned StarveLimit = 4
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam logic [3:0] StarveMax = 4'(StarveLimit);

  logic [3:0]  starve_q;
  owner_e      owner_q;
  logic        err_q;

  logic        starved;
  logic        gnt_instr;
  logic        gnt_data;
  logic        any_gnt;
  logic [31:0] sel_addr;
  logic        sel_hit;
  logic        mem_req;

  // Instruction wins ties until data has lost StarveLimit times in a row.
  assign starved   = (starve_q == StarveMax);
  assign gnt_instr = instr_req_i & ~(data_req_i & starved);
  assign gnt_data  = data_req_i & ~gnt_instr;
  assign any_gnt   = gnt_instr | gnt_data;

  assign sel_addr  = gnt_instr ? instr_addr_i : data_addr_i;
  assign sel_hit   = ((sel_addr & ~MemMask) == MemStart);
  // Out-of-window accesses are granted but never reach the SRAM.
  assign mem_req   = any_gnt & sel_hit;

  assign instr_gnt_o = gnt_instr;
  assign data_gnt_o  = gnt_data;

  always_comb begin
    mem_req_o   = mem_req;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (mem_req) begin
      mem_addr_o = sel_addr;
      if (gnt_instr) begin
        mem_be_o = 4'hF;
      end else begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end
    end
  end

  // Starve counter only measures consecutive losses of a data request that is
  // still waiting; a dropped data request or a data win starts it over.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      starve_q <= 4'd0;
    end else if (!data_req_i || gnt_data) begin
      starve_q <= 4'd0;
    end else if (gnt_instr && !starved) begin
      starve_q <= starve_q + 4'd1;
    end
  end

  // One-deep response tag, reloaded every cycle from that cycle's grant.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
    end else begin
      owner_q <= gnt_instr ? OWN_INSTR : (gnt_data ? OWN_DATA : OWN_NONE);
      err_q   <= any_gnt & ~sel_hit;
    end
  end

  // Response routing: rdata is forced to zero unless this port owns a hit access.
  always_comb begin
    instr_rvalid_o = (owner_q == OWN_INSTR);
    data_rvalid_o  = (owner_q == OWN_DATA);
    instr_err_o    = instr_rvalid_o & err_q;
    data_err_o     = data_rvalid_o & err_q;
    instr_rdata_o  = (instr_rvalid_o && !err_q) ? mem_rdata_i : 32'h0;
    data_rdata_o   = (data_rvalid_o && !err_q) ? mem_rdata_i : 32'h0;
  end

  // SRAM must answer exactly the hit accesses issued the cycle before.
  a_no_unexpected_rvalid : assert property (
    @(posedge clk_sys) disable iff (!rst_sys_n)
      mem_rvalid_i |-> (owner_q != OWN_NONE && !err_q));

  a_no_missing_rvalid : assert property (
    @(posedge clk_sys) disable iff (!rst_sys_n)
      (owner_q != OWN_NONE && !err_q) |-> mem_rvalid_i);

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  localparam logic [31:0] MEM_START = 32'h0000_0000;
  localparam logic [31:0] MEM_MASK  = 32'h0000_FFFF;
  localparam int          LIMIT     = 4;
  localparam logic [7:0]  W_I = "I";
  localparam logic [7:0]  W_D = "D";
  localparam logic [7:0]  W_N = "-";

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  always #5 clk_sys = ~clk_sys;

  sram_arbiter #(
    .MemStart(MEM_START), .MemMask(MEM_MASK), .StarveLimit(LIMIT)
  ) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  // ---------------- SRAM behavioural model (the device under arbitration) ----
  logic [31:0] sram [0:16383];

  always @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      mem_rvalid_i <= 1'b0;
      mem_rdata_i  <= 32'h0;
    end else begin
      mem_rvalid_i <= mem_req_o;
      mem_rdata_i  <= 32'h0;
      if (mem_req_o) begin
        if (mem_we_o) begin
          for (int b = 0; b < 4; b++)
            if (mem_be_o[b]) sram[mem_addr_o[15:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end else begin
          mem_rdata_i <= sram[mem_addr_o[15:2]];
        end
      end
    end
  end

  // ---------------- reference model state -------------------------------------
  typedef struct {
    logic        vi;
    logic        vd;
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
  } resp_t;

  logic [31:0] ref_mem [0:16383];
  resp_t       pend;
  int          losses;   // consecutive instr wins over a waiting data request
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic in_window(input logic [31:0] a);
    return (a & ~MEM_MASK) == MEM_START;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend   = '{vi: 1'b0, vd: 1'b0, err: 1'b0, chk_rd: 1'b0, rdata: 32'h0};
    losses = 0;
  endtask

  // Drive one cycle of requests at the falling edge, check everything the DUT
  // shows in that cycle, then advance the model past the following rising edge.
  task automatic apply(input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic dwe, input logic [3:0] dbe,
                       input logic [31:0] daddr, input logic [31:0] dwdata,
                       output logic [7:0] win);
    logic [31:0] a;
    logic        hit;
    @(negedge clk_sys);
    instr_req_i  = ireq;  instr_addr_i = iaddr;
    data_req_i   = dreq;  data_we_i    = dwe;   data_be_i = dbe;
    data_addr_i  = daddr; data_wdata_i = dwdata;
    #1;
    if (ireq && dreq)  win = (losses >= LIMIT) ? W_D : W_I;
    else if (ireq)     win = W_I;
    else if (dreq)     win = W_D;
    else               win = W_N;
    a   = (win == W_I) ? iaddr : daddr;
    hit = in_window(a) && (win != W_N);

    chk("instr_gnt", 32'(instr_gnt_o), 32'(win == W_I));
    chk("data_gnt",  32'(data_gnt_o),  32'(win == W_D));
    chk("mem_req",   32'(mem_req_o),   32'(hit));
    chk("mem_addr",  mem_addr_o,  hit ? a : 32'h0);
    chk("mem_we",    32'(mem_we_o),   32'(hit && win == W_D && dwe));
    chk("mem_be",    32'(mem_be_o),   !hit ? 32'h0 : (win == W_I ? 32'hF : 32'(dbe)));
    chk("mem_wdata", mem_wdata_o, (hit && win == W_D) ? dwdata : 32'h0);

    chk("instr_rvalid", 32'(instr_rvalid_o), 32'(pend.vi));
    chk("instr_err",    32'(instr_err_o),    32'(pend.vi && pend.err));
    if (pend.vi) chk("instr_rdata", instr_rdata_o, pend.rdata);
    chk("data_rvalid",  32'(data_rvalid_o),  32'(pend.vd));
    chk("data_err",     32'(data_err_o),     32'(pend.vd && pend.err));
    if (pend.vd && pend.chk_rd) chk("data_rdata", data_rdata_o, pend.rdata);

    pend.vi     = (win == W_I);
    pend.vd     = (win == W_D);
    pend.err    = (win != W_N) && !hit;
    pend.chk_rd = !(win == W_D && hit && dwe);
    pend.rdata  = (hit && pend.chk_rd) ? ref_mem[a[15:2]] : 32'h0;
    if (win == W_D && hit && dwe)
      for (int b = 0; b < 4; b++)
        if (dbe[b]) ref_mem[a[15:2]][8*b +: 8] = dwdata[8*b +: 8];
    losses = (dreq && win == W_I) ? ((losses + 1 > LIMIT) ? LIMIT : losses + 1) : 0;
  endtask

  // ---------------- directed vectors ------------------------------------------
  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        exp_gi;
    logic        exp_gd;
    logic        exp_mreq;
    logic [3:0]  exp_be;
    int          prev_kind;  // 0 none, 1 instr_rdata, 2 data_rdata[15:0], 3 data_err
    logic [31:0] prev_val;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [7:0] w;
    logic [7:0] exp_w;
    vecs[0] = '{1, 32'h0000_0080, 0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 1, 4'hF, 0, 32'h0};
    vecs[1] = '{0, 32'h0,         1, 1, 4'h3, 32'h0000_1000, 32'hDEADBEEF, 0, 1, 1, 4'h3, 1, 32'h13};
    vecs[2] = '{0, 32'h0,         1, 0, 4'hF, 32'h0000_1000, 32'h0,         0, 1, 1, 4'hF, 0, 32'h0};
    vecs[3] = '{0, 32'h0,         1, 0, 4'hF, 32'h0002_0000, 32'h0,         0, 1, 0, 4'h0, 2, 32'hBEEF};
    vecs[4] = '{1, 32'h0003_0000, 0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 0, 4'h0, 3, 32'h1};
    vecs[5] = '{0, 32'h0,         0, 0, 4'h0, 32'h0,         32'h0,         0, 0, 0, 4'h0, 0, 32'h0};
    vecs[6] = '{1, 32'h0000_0084, 1, 0, 4'hF, 32'h0000_0200, 32'h0,         1, 0, 1, 4'hF, 0, 32'h0};
    vecs[7] = '{1, 32'h0000_0088, 0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 1, 4'hF, 0, 32'h0};

    for (int i = 0; i < 16384; i++) begin
      sram[i]    = init_word(i);
      ref_mem[i] = init_word(i);
    end
    sram[32]    = 32'h0000_0013;
    ref_mem[32] = 32'h0000_0013;

    rst_sys_n = 1'b0;
    instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_we_i = 0;
    data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
    chk("rst_data_rvalid",  32'(data_rvalid_o),  32'h0);
    chk("rst_errs",         32'({instr_err_o, data_err_o}), 32'h0);
    chk("rst_rdata",        instr_rdata_o | data_rdata_o, 32'h0);
    #1 rst_sys_n = 1'b1;

    // Table of directed accesses.
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe, vecs[i].dbe,
            vecs[i].daddr, vecs[i].dwdata, w);
      chk($sformatf("vec%0d_gi", i),   32'(instr_gnt_o), 32'(vecs[i].exp_gi));
      chk($sformatf("vec%0d_gd", i),   32'(data_gnt_o),  32'(vecs[i].exp_gd));
      chk($sformatf("vec%0d_mreq", i), 32'(mem_req_o),   32'(vecs[i].exp_mreq));
      chk($sformatf("vec%0d_be", i),   32'(mem_be_o),    32'(vecs[i].exp_be));
      case (vecs[i].prev_kind)
        1: chk($sformatf("vec%0d_prev_irdata", i), instr_rdata_o, vecs[i].prev_val);
        2: chk($sformatf("vec%0d_prev_drdata", i), {16'h0, data_rdata_o[15:0]}, vecs[i].prev_val);
        3: chk($sformatf("vec%0d_prev_derr", i), {data_rdata_o[30:0], data_err_o}, vecs[i].prev_val);
        default: ;
      endcase
    end

    // Both ports held: I,I,I,I,D repeating.
    apply(0, 0, 0, 0, 0, 0, 0, w);
    for (int k = 0; k < 15; k++) begin
      apply(1, 32'h100 + 32'(4 * k), 1, 0, 4'hF, 32'h400 + 32'(4 * k), 0, w);
      exp_w = (k % 5 == 4) ? W_D : W_I;
      chk($sformatf("starve_seq%0d", k), 32'(w), 32'(exp_w));
    end

    // Alternating single-port accesses, no bubbles.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) apply(1, 32'h0000_0080, 0, 0, 0, 0, 0, w);
      else            apply(0, 0, 1, 0, 4'hF, 32'h0000_1000, 0, w);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] ia, da;
      ia = ($urandom_range(0, 9) == 0) ? (32'h0002_0000 | ($urandom & 32'hFFFC))
                                       : ($urandom & 32'h0000_FFFC);
      da = ($urandom_range(0, 9) == 0) ? (32'h8000_0000 | ($urandom & 32'hFFFC))
                                       : ($urandom & 32'h0000_FFFC);
      apply($urandom_range(0, 3) != 0, ia, $urandom_range(0, 3) != 0,
            1'($urandom), 4'($urandom), da, $urandom, w);
    end

    // Reset right after a data grant: response dropped, counter cleared.
    apply(0, 0, 0, 0, 0, 0, 0, w);
    apply(1, 32'h0, 1, 0, 4'hF, 32'h300, 0, w);
    apply(0, 0, 1, 0, 4'hF, 32'h0000_0300, 0, w);
    @(negedge clk_sys);
    rst_sys_n = 1'b0;
    instr_req_i = 1; instr_addr_i = 32'h0; data_req_i = 1; data_addr_i = 32'h0000_0304;
    #1;
    chk("rst_mid_data_rvalid", 32'(data_rvalid_o), 32'h0);
    @(negedge clk_sys);
    #1;
    chk("rst_mid_data_rvalid2", 32'(data_rvalid_o), 32'h0);
    @(posedge clk_sys);
    #2 rst_sys_n = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      apply(1, 32'h0, 1, 0, 4'hF, 32'h0000_0304, 0, w);
      if (k == 0) chk("post_rst_data_rvalid", 32'(data_rvalid_o), 32'h0);
      exp_w = (k == 4) ? W_D : W_I;
      chk($sformatf("post_rst_seq%0d", k), 32'(w), 32'(exp_w));
    end
    apply(0, 0, 0, 0, 0, 0, 0, w);
    apply(0, 0, 0, 0, 0, 0, 0, w);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
